mips_dump_sequencer: RTL and testbench

Debug-side sequencer that dumps the full MIPS architectural state over the 32-bit UART transmit path after a program ends or on a step request. On `i_start` it walks the PC, every register-file entry and a window of data memory. For each word it drives the debug read pointers into the MIPS, captures the returned word, and hands it to the UART with a single-word start/done handshake. It sits between the debug unit (command source), the MIPS debug read ports and `uart_32b`, and owns the TX path for the duration of a dump.

---
 rtl/mips_dump_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_mips_dump_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dump_sequencer.sv
// Dumps PC, register file and a data-memory window over uart_32b.
// DUMP_CHECKSUM_EN appends a mod-2^32 sum of all dumped words.
module mips_dump_sequencer #(
  parameter int NB_DATA        = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_MEM_ADDRESS = 7,
  parameter int N_REGS         = 32,
  parameter int N_MEM_WORDS    = 128,
  parameter int NB_TIMEOUT     = 20
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic                      i_abort,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error,
  output logic [NB_REG_ADDRESS-1:0] o_debug_ptr_reg,
  output logic [NB_MEM_ADDRESS-1:0] o_debug_ptr_mem,
  input  logic [NB_DATA-1:0]        i_debug_read_reg,
  input  logic [NB_DATA-1:0]        i_debug_read_mem,
  input  logic [NB_DATA-1:0]        i_read_pc,
  output logic [NB_DATA-1:0]        o_tx_data,
  output logic                      o_tx_start,
  input  logic                      i_tx_done
);

  localparam int NB_IDX =
    (NB_REG_ADDRESS > NB_MEM_ADDRESS) ?
    NB_REG_ADDRESS : NB_MEM_ADDRESS;

  localparam logic [NB_IDX-1:0] REG_LAST =
    NB_IDX'(N_REGS - 1);
  localparam logic [NB_IDX-1:0] MEM_LAST =
    NB_IDX'(N_MEM_WORDS - 1);
  localparam logic [NB_TIMEOUT-1:0] WDOG_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_CAP,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM,
    SEC_CSUM
  } sec_e;

  state_e state_q, state_d;
  sec_e   sec_q, sec_d, sec_nxt;

  logic [NB_IDX-1:0]         idx_q, idx_d;
  logic [NB_TIMEOUT-1:0]     wdog_q, wdog_d, wdog_inc;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      tx_start_q, tx_start_d;
  logic [NB_DATA-1:0]        tx_data_q, tx_data_d;
  logic [NB_REG_ADDRESS-1:0] ptr_reg_q, ptr_reg_d;
  logic [NB_MEM_ADDRESS-1:0] ptr_mem_q, ptr_mem_d;
  logic [NB_DATA-1:0]        src;
  logic                      sec_end, sec_last;
  logic                      wdog_sat, accept;
`ifdef DUMP_CHECKSUM_EN
  logic [NB_DATA-1:0]        csum_q, csum_d;
`endif

  assign accept   = (state_q == S_IDLE) && i_start;
  assign wdog_inc = wdog_q + 1'b1;
  assign wdog_sat = (wdog_inc == WDOG_MAX);

  always_comb begin
    sec_end = 1'b1;
    sec_nxt = SEC_PC;
    unique case (sec_q)
      SEC_PC:  sec_nxt = SEC_REG;
      SEC_REG: begin
        sec_end = (idx_q == REG_LAST);
        sec_nxt = SEC_MEM;
      end
      SEC_MEM: begin
        sec_end = (idx_q == MEM_LAST);
`ifdef DUMP_CHECKSUM_EN
        sec_nxt = SEC_CSUM;
`endif
      end
      default: sec_nxt = SEC_PC;
    endcase
  end

`ifdef DUMP_CHECKSUM_EN
  assign sec_last = (sec_q == SEC_CSUM);
`else
  assign sec_last = (sec_q == SEC_MEM);
`endif

  always_comb begin
    src = i_read_pc;
    unique case (sec_q)
      SEC_REG: src = i_debug_read_reg;
      SEC_MEM: src = i_debug_read_mem;
`ifdef DUMP_CHECKSUM_EN
      SEC_CSUM: src = csum_q;
`endif
      default: src = i_read_pc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= S_IDLE;
      sec_q      <= SEC_PC;
      idx_q      <= '0;
      wdog_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ptr_reg_q  <= '0;
      ptr_mem_q  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sec_q      <= sec_d;
      idx_q      <= idx_d;
      wdog_q     <= wdog_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ptr_reg_q  <= ptr_reg_d;
      ptr_mem_q  <= ptr_mem_d;
`ifdef DUMP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: if (i_start) state_d = S_SEL;
        S_SEL:  state_d = S_CAP;
        S_CAP:  state_d = S_SEND;
        S_SEND: state_d = S_WAIT;
        S_WAIT: begin
          if (i_tx_done)     state_d = S_NEXT;
          else if (wdog_sat) state_d = S_IDLE;
        end
        S_NEXT: begin
          if (sec_end && sec_last) state_d = S_DONE;
          else                     state_d = S_SEL;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sec_d      = sec_q;
    idx_d      = idx_q;
    wdog_d     = wdog_q;
    error_d    = error_q;
    tx_data_d  = tx_data_q;
    ptr_reg_d  = ptr_reg_q;
    ptr_mem_d  = ptr_mem_q;
`ifdef DUMP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_q == S_DONE) && !i_abort;
    tx_start_d = (state_q == S_SEND) && !i_abort;

    if (accept && !i_abort) begin
      sec_d   = SEC_PC;
      idx_d   = '0;
      error_d = 1'b0;
`ifdef DUMP_CHECKSUM_EN
      csum_d  = '0;
`endif
    end

    if (state_q == S_SEL) begin
      if (sec_q == SEC_REG)
        ptr_reg_d = idx_q[NB_REG_ADDRESS-1:0];
      if (sec_q == SEC_MEM)
        ptr_mem_d = idx_q[NB_MEM_ADDRESS-1:0];
    end

    if (state_q == S_CAP) begin
      tx_data_d = src;
`ifdef DUMP_CHECKSUM_EN
      if (sec_q != SEC_CSUM)
        csum_d = csum_q + src;
`endif
    end

    // Watchdog restarts on every entry into WAIT.
    if (state_q == S_WAIT) begin
      wdog_d = wdog_inc;
      if (!i_abort && !i_tx_done && wdog_sat)
        error_d = 1'b1;
    end else if (state_d == S_WAIT) begin
      wdog_d = '0;
    end

    if (state_q == S_NEXT && !i_abort) begin
      if (sec_end) begin
        sec_d = sec_nxt;
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_error         = error_q;
  assign o_tx_start      = tx_start_q;
  assign o_tx_data       = tx_data_q;
  assign o_debug_ptr_reg = ptr_reg_q;
  assign o_debug_ptr_mem = ptr_mem_q;

endmodule

// File: tb/tb_mips_dump_sequencer.sv
// Scoreboard bench for mips_dump_sequencer (4 regs, 2 mem words).
// Words expected from a dump: 0x40, 0x100..0x103, 0xA0, 0xA1.
module tb_mips_dump_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        uart_done = 1'b0;
  logic        stim_done = 1'b0;
  logic        tx_done;
  logic        busy, done, error, tx_start;
  logic [4:0]  ptr_reg;
  logic [6:0]  ptr_mem;
  logic [31:0] rd_reg, rd_mem, pc, tx_data;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int done_q = 0;
  int last_done_edge = 0;
  int start_edge = 0;
  bit uart_en = 1'b1;
  logic [31:0] exp_q[$];

  assign tx_done = uart_done | stim_done;
  assign pc      = 32'h40;
  assign rd_reg  = 32'h100 + 32'(ptr_reg);
  assign rd_mem  = 32'hA0 + 32'(ptr_mem);

  mips_dump_sequencer #(
    .NB_DATA(32),
    .NB_REG_ADDRESS(5),
    .NB_MEM_ADDRESS(7),
    .N_REGS(4),
    .N_MEM_WORDS(2),
    .NB_TIMEOUT(4)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_start(start),
    .i_abort(abort),
    .o_busy(busy),
    .o_done(done),
    .o_error(error),
    .o_debug_ptr_reg(ptr_reg),
    .o_debug_ptr_mem(ptr_mem),
    .i_debug_read_reg(rd_reg),
    .i_debug_read_mem(rd_mem),
    .i_read_pc(pc),
    .o_tx_data(tx_data),
    .o_tx_start(tx_start),
    .i_tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h",
               name, act, exp);
    end
  endtask

  task automatic push_full();
    exp_q.push_back(32'h40);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    for (int i = 0; i < 2; i++) exp_q.push_back(32'hA0 + 32'(i));
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(32'h0000_0587);
`endif
    done_q++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_edge = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tx(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_start && n < budget);
    if (!tx_start) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no tx_start within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_uart(input int old, input int budget);
    int n = 0;
    while (last_done_edge == old && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (last_done_edge == old) begin
      n_checks++;
      n_fail++;
      $display("FAIL uart_wait: no tx_done within %0d cycles", budget);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles", name, budget);
    end
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_done_left"}, 32'(done_q), 32'd0);
  endtask

  // UART model: done pulse sampled 10 edges after the start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start && uart_en) begin
        repeat (9) @(negedge clk);
        uart_done = 1'b1;
        last_done_edge = cyc + 1;
        @(negedge clk);
        uart_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every start pulse and done pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_extra: got word 0x%0h, required none",
                   tx_data);
        end else begin
          chk("tx_word", tx_data, exp_q.pop_front());
        end
      end
      if (done) begin
        if (done_q == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL done_extra: got o_done=1, required 0");
        end else begin
          done_q--;
          chk("done_latency", 32'(cyc), 32'(last_done_edge + 2));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end, required $finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int d, old;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    chk("rst_ptr_reg", 32'(ptr_reg), 32'd0);
    chk("rst_ptr_mem", 32'(ptr_mem), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Full dump with latency checks
    push_full();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_tx("first_tx", 10);
    chk("first_tx_edge", 32'(cyc), 32'(start_edge + 3));
    old = last_done_edge;
    wait_uart(old, 30);
    d = last_done_edge;
    wait_tx("second_tx", 20);
    chk("word_gap_edge", 32'(cyc), 32'(d + 4));
    wait_idle("dump1", 400);
    repeat (3) @(negedge clk);
    chk_drained("dump1");

    // Abort in the WAIT of reg 2
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h101);
    exp_q.push_back(32'h102);
    pulse_start();
    for (int i = 0; i < 4; i++) wait_tx("abort_tx", 40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_error", 32'(error), 32'd0);
    repeat (30) @(negedge clk);
    chk_drained("abort");
    push_full();
    pulse_start();
    wait_idle("restart", 400);
    repeat (3) @(negedge clk);
    chk_drained("restart");

    // Watchdog: UART never answers
    uart_en = 1'b0;
    exp_q.push_back(32'h40);
    pulse_start();
    wait_tx("wdog_tx", 10);
    d = cyc;
    for (int i = 0; i < 40 && !error; i++) @(negedge clk);
    chk("wdog_cycles", 32'(cyc - d), 32'd15);
    chk("wdog_error", 32'(error), 32'd1);
    chk("wdog_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("wdog_sticky", 32'(error), 32'd1);
    uart_en = 1'b1;
    push_full();
    pulse_start();
    chk("error_cleared", 32'(error), 32'd0);
    wait_idle("after_wdog", 400);
    repeat (3) @(negedge clk);
    chk_drained("wdog");

    // Start during a dump and tx_done during SEL
    push_full();
    pulse_start();
    old = last_done_edge;
    wait_uart(old, 40);
    d = last_done_edge;
    while (cyc < d + 1) @(negedge clk);
    stim_done = 1'b1;
    start = 1'b1;
    @(negedge clk);
    stim_done = 1'b0;
    start = 1'b0;
    wait_idle("ignored", 400);
    repeat (3) @(negedge clk);
    chk_drained("ignored");

    // Reset during CAP
    pulse_start();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_tx_data", tx_data, 32'd0);
    chk("mid_rst_ptr_reg", 32'(ptr_reg), 32'd0);
    chk("mid_rst_ptr_mem", 32'(ptr_mem), 32'd0);
    chk("mid_rst_tx_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk_drained("post_rst");
    push_full();
    pulse_start();
    wait_idle("after_rst", 400);
    repeat (3) @(negedge clk);
    chk_drained("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
